// File: rtl/inst_assembler.sv
// inst_assembler: packs decoded instruction fields into 16-bit words, buffers
// them in a small FIFO and streams them into instruction memory at
// sequential addresses starting from a programmable start address.
//
// Optional feature macro: INST_ASSEMBLER_CHECKSUM_EN adds a running XOR of
// every completed write's data on output checksum.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, start_addr        begin a load session (IDLE only), first address
//   in_valid/in_ready        field-bundle handshake; in_last ends the session
//   fmt, cond, op_code,      instruction fields (fmt 0 = register format,
//   dest_reg, src_reg_1/2,   fmt 1 = shift format)
//   shift
//   mem_we/mem_addr/         memory write port; a write completes on
//   mem_wdata/mem_ready      mem_we && mem_ready
//   busy, done, word_count   session status, done pulse, words written
//   checksum                 (macro only) XOR of written data
//
// DEPTH must be a power of two and at least 2.
module inst_assembler #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic              fmt,
  input  logic [1:0]        cond,
  input  logic [3:0]        op_code,
  input  logic [2:0]        dest_reg,
  input  logic [2:0]        src_reg_1,
  input  logic [2:0]        src_reg_2,
  input  logic [6:0]        shift,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
`ifdef INST_ASSEMBLER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [15:0]       r_fifo [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_session;
  logic              w_push;
  logic              w_pop;
  logic [15:0]       w_word;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                     (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
  assign w_session = (r_state == S_LOAD) || (r_state == S_DRAIN);

  // Outputs decode registered state only; no input-to-output paths.
  assign in_ready   = (r_state == S_LOAD) && !w_full;
  assign mem_we     = w_session && !w_empty;
  assign mem_wdata  = mem_we ? r_fifo[r_rptr[IDX_W-1:0]] : 16'h0000;
  assign mem_addr   = r_addr;
  assign busy       = w_session;
  assign done       = (r_state == S_DONE);
  assign word_count = r_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = mem_we && mem_ready;

  // Field packing; the unused fields of each format are dropped here.
  assign w_word = fmt ? {cond, op_code, dest_reg, shift}
                      : {cond, op_code, dest_reg, src_reg_1, src_reg_2, 1'b0};

  // FIFO storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr[IDX_W-1:0]] <= w_word;
    end
  end

  // Session FSM, FIFO pointers, address and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_addr  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= start_addr;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_push && in_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
        r_addr <= r_addr + ADDR_W'(1);
        if (r_count != {CNT_W{1'b1}}) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef INST_ASSEMBLER_CHECKSUM_EN
  logic [15:0] r_csum;

  // Running XOR of completed writes; frozen once the FIFO has drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_csum <= '0;
    end else if (w_pop) begin
      r_csum <= r_csum ^ mem_wdata;
    end
  end

  assign checksum = r_csum;
`endif

endmodule

// File: tb/tb_inst_assembler.sv
// Randomized self-checking bench for inst_assembler. A queue-based
// reference model tracks queued words, the next write address, the word
// count and the session phase, and every cycle is compared against it.
module tb_inst_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic        fmt;
  logic [1:0]  cond;
  logic [3:0]  op_code;
  logic [2:0]  dest_reg;
  logic [2:0]  src_reg_1;
  logic [2:0]  src_reg_2;
  logic [6:0]  shift;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic [8:0]  word_count;
`ifdef INST_ASSEMBLER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;

  inst_assembler #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .fmt        (fmt),
    .cond       (cond),
    .op_code    (op_code),
    .dest_reg   (dest_reg),
    .src_reg_1  (src_reg_1),
    .src_reg_2  (src_reg_2),
    .shift      (shift),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
`ifdef INST_ASSEMBLER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state.
  logic [15:0] exp_q[$];
  logic [7:0]  exp_addr = 8'h00;
  int          exp_cnt = 0;
  logic [15:0] exp_csum = 16'h0000;
  bit          m_load = 1'b0;
  bit          m_sess = 1'b0;
  int          done_cnt = 0;
  bit          acc = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_addr = 8'h00;
  logic [15:0] prev_data = 16'h0000;
  logic [15:0] wr_data_log[$];
  logic [7:0]  wr_addr_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instruction word from field values, by weighted sums of the fields.
  function automatic logic [15:0] enc_model(input int f, input int c, input int o,
                                            input int d, input int s1, input int s2,
                                            input int sh);
    int v;
    v = c * 16384 + o * 1024 + d * 128;
    if (f != 0) v = v + sh;
    else        v = v + s1 * 16 + s2 * 2;
    return 16'(v);
  endfunction

  // One clock: compare at the falling edge, account handshakes, advance.
  task automatic step();
    logic [15:0] e;
    @(negedge clk);
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(m_load && exp_q.size() < 4));
      chk("mem_we", 32'(mem_we), 32'(exp_q.size() != 0));
      if (!mem_we) chk("wdata_idle", 32'(mem_wdata), 32'h0);
      if (m_sess) begin
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("word_count", 32'(word_count), 32'(exp_cnt));
`ifdef INST_ASSEMBLER_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(exp_csum));
`endif
      end
      if (m_load) chk("busy_load", 32'(busy), 32'h1);
      if (!m_sess) chk("busy_idle", 32'(busy), 32'h0);
      if (prev_stall) begin
        chk("hold_we", 32'(mem_we), 32'h1);
        chk("hold_addr", 32'(mem_addr), 32'(prev_addr));
        chk("hold_data", 32'(mem_wdata), 32'(prev_data));
      end
      if (done) begin
        chk("done_when", 32'(m_sess && !m_load && exp_q.size() == 0), 32'h1);
        chk("done_count", 32'(word_count), 32'(exp_cnt));
        m_sess = 1'b0;
        done_cnt++;
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", 32'(mem_we), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("wdata", 32'(mem_wdata), 32'(e));
          exp_csum = exp_csum ^ e;
        end
        chk("waddr", 32'(mem_addr), 32'(exp_addr));
        wr_data_log.push_back(mem_wdata);
        wr_addr_log.push_back(mem_addr);
        exp_addr = 8'((int'(exp_addr) + 1) % 256);
        exp_cnt++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(enc_model(int'(fmt), int'(cond), int'(op_code), int'(dest_reg),
                                  int'(src_reg_1), int'(src_reg_2), int'(shift)));
        if (in_last) m_load = 1'b0;
      end
      if (start && !m_sess) begin
        m_sess   = 1'b1;
        m_load   = 1'b1;
        exp_addr = start_addr;
        exp_cnt  = 0;
        exp_csum = 16'h0000;
        exp_q.delete();
      end
    end else begin
      acc = 1'b0;
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_load     = 1'b0;
      m_sess     = 1'b0;
      prev_stall = 1'b0;
      exp_cnt    = 0;
      exp_csum   = 16'h0000;
    end
    #1;
  endtask

  task automatic rand_bundle(input bit last);
    fmt       = 1'($urandom());
    cond      = 2'($urandom());
    op_code   = 4'($urandom());
    dest_reg  = 3'($urandom());
    src_reg_1 = 3'($urandom());
    src_reg_2 = 3'($urandom());
    shift     = 7'($urandom());
    in_last   = last;
  endtask

  task automatic dir_bundle(input int k, input bit last);
    rand_bundle(last);
    if (k == 0) begin
      fmt = 1'b0; cond = 2'b01; op_code = 4'b0011; dest_reg = 3'd5;
      src_reg_1 = 3'd2; src_reg_2 = 3'd7;
    end else begin
      fmt = 1'b1; cond = 2'b11; op_code = 4'b1010; dest_reg = 3'd1; shift = 7'h55;
    end
  endtask

  // Optionally start, push n bundles, then wait (bounded) for done.
  task automatic run_session(input logic [7:0] a, input int n, input int pv,
                             input int pr, input bit fixed, input bit do_start);
    int k;
    int guard;
    int d0;
    d0 = done_cnt;
    if (do_start) begin
      start = 1'b1; start_addr = a; in_valid = 1'b0; mem_ready = 1'b0;
      step();
      start = 1'b0;
    end
    k = 0;
    guard = 0;
    while (k < n && guard < 2000) begin
      in_valid = ($urandom_range(99) < pv);
      if (fixed) dir_bundle(k, k == n - 1);
      else       rand_bundle(k == n - 1);
      mem_ready = ($urandom_range(99) < pr);
      step();
      if (acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (done_cnt == d0 && guard < 500) begin
      mem_ready = ($urandom_range(99) < pr) || (guard > 100);
      step();
      guard++;
    end
    chk("session_done", 32'(done_cnt), 32'(d0 + 1));
    mem_ready = 1'b0;
    step();
  endtask

  initial begin
    int acc_n;
    int guard;
    rst = 1'b1; start = 1'b0; start_addr = 8'h00; in_valid = 1'b0; mem_ready = 1'b0;
    rand_bundle(1'b0);
    repeat (3) step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_word_count", 32'(word_count), 32'h0);

    // in_valid in IDLE must never push or write.
    in_valid = 1'b1; mem_ready = 1'b1;
    repeat (6) begin rand_bundle(1'b1); step(); end
    in_valid = 1'b0;
    chk("idle_no_write", 32'(wr_data_log.size()), 32'h0);

    // Register-format single word.
    wr_data_log.delete(); wr_addr_log.delete();
    run_session(8'h10, 1, 100, 100, 1'b1, 1'b1);
    chk("enc1_size", 32'(wr_data_log.size()), 32'h1);
    if (wr_data_log.size() >= 1) begin
      chk("enc_reg", 32'(wr_data_log[0]), 32'h4EAE);
      chk("enc_reg_addr", 32'(wr_addr_log[0]), 32'h10);
    end
    chk("enc1_wc", 32'(word_count), 32'h1);

    // Register then shift format; checksum over both.
    wr_data_log.delete(); wr_addr_log.delete();
    run_session(8'h10, 2, 100, 100, 1'b1, 1'b1);
    chk("enc2_size", 32'(wr_data_log.size()), 32'h2);
    if (wr_data_log.size() >= 2) begin
      chk("enc_reg2", 32'(wr_data_log[0]), 32'h4EAE);
      chk("enc_shift", 32'(wr_data_log[1]), 32'hE8D5);
    end
`ifdef INST_ASSEMBLER_CHECKSUM_EN
    chk("checksum_final", 32'(checksum), 32'hA67B);
`endif

    // Backpressure: FIFO fills to DEPTH, start is ignored mid-session.
    wr_data_log.delete(); wr_addr_log.delete();
    start = 1'b1; start_addr = 8'h40; step(); start = 1'b0;
    mem_ready = 1'b0; in_valid = 1'b1; acc_n = 0;
    repeat (8) begin rand_bundle(1'b0); step(); if (acc) acc_n++; end
    chk("bp_accepts", 32'(acc_n), 32'h4);
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    start = 1'b1; start_addr = 8'h99; step(); start = 1'b0;
    step();
    chk("ign_start_addr", 32'(mem_addr), 32'h40);
    chk("ign_start_wc", 32'(word_count), 32'h0);
    mem_ready = 1'b1;
    repeat (6) step();
    run_session(8'h00, 1, 100, 100, 1'b0, 1'b0);
    chk("bp_size", 32'(wr_addr_log.size()), 32'h5);
    for (int i = 0; i < wr_addr_log.size(); i++)
      chk("bp_addr", 32'(wr_addr_log[i]), 32'(8'h40 + i));

    // Address wrap.
    wr_data_log.delete(); wr_addr_log.delete();
    run_session(8'hFE, 3, 80, 70, 1'b0, 1'b1);
    chk("wrap_size", 32'(wr_addr_log.size()), 32'h3);
    if (wr_addr_log.size() >= 3) begin
      chk("wrap_a0", 32'(wr_addr_log[0]), 32'hFE);
      chk("wrap_a1", 32'(wr_addr_log[1]), 32'hFF);
      chk("wrap_a2", 32'(wr_addr_log[2]), 32'h00);
    end
    chk("wrap_wc", 32'(word_count), 32'h3);

    // Reset mid-session with two words queued.
    start = 1'b1; start_addr = 8'h20; step(); start = 1'b0;
    mem_ready = 1'b0; in_valid = 1'b1; acc_n = 0; guard = 0;
    while (acc_n < 2 && guard < 20) begin
      rand_bundle(1'b0); step(); if (acc) acc_n++; guard++;
    end
    in_valid = 1'b0;
    chk("mid_queued", 32'(acc_n), 32'h2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_mem_we", 32'(mem_we), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_in_ready", 32'(in_ready), 32'h0);
    chk("mid_wc", 32'(word_count), 32'h0);
    wr_data_log.delete(); wr_addr_log.delete();
    mem_ready = 1'b1;
    run_session(8'h30, 3, 90, 90, 1'b0, 1'b1);
    chk("post_rst_size", 32'(wr_addr_log.size()), 32'h3);

    // Randomized sessions.
    for (int s = 0; s < 25; s++) begin
      run_session(8'($urandom()), int'($urandom_range(1, 12)),
                  int'($urandom_range(30, 100)), int'($urandom_range(20, 100)),
                  1'b0, 1'b1);
      repeat (int'($urandom_range(0, 3))) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
